// File: rtl/nibble_alu_sched.sv
// nibble_alu_sched: round-robin arbiter that runs a W-bit add/subtract nibble-serially
// through an external registered 4-bit sumador, chaining RCO back into Cin.
`default_nettype none

module nibble_alu_sched #(
  parameter int NNIB = 8
) (
  input  logic                CLK,
  input  logic                RESET_L,
  input  logic                REQ0,
  input  logic                REQ1,
  input  logic                SUB0,
  input  logic                SUB1,
  input  logic [4*NNIB-1:0]   OPA0,
  input  logic [4*NNIB-1:0]   OPB0,
  input  logic [4*NNIB-1:0]   OPA1,
  input  logic [4*NNIB-1:0]   OPB1,
  output logic                ACK0,
  output logic                ACK1,
  output logic [4*NNIB-1:0]   RES,
  output logic                CO,
  output logic                GNT,
  output logic                BUSY,
  output logic [3:0]          A,
  output logic [3:0]          B,
  output logic                Cin,
  output logic                ENB,
  output logic [1:0]          MODO,
  input  logic [3:0]          Q,
  input  logic                RCO
);

  localparam int W  = 4 * NNIB;
  localparam int IW = (NNIB > 1) ? $clog2(NNIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2,
    S_CLR  = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [IW-1:0]   idx;
  logic            rr_ptr;
  logic            gnt;
  logic            sub_q;
  logic [W-1:0]    opa_q;
  logic [W-1:0]    opb_q;
  logic [W-1:0]    acc;
  logic [W-1:0]    res_next;
  logic            grant;
  logic            winner;
  logic [3:0]      opa_nib;
  logic [3:0]      opb_nib;

  assign opa_nib = opa_q[{idx, 2'b00} +: 4];
  assign opb_nib = opb_q[{idx, 2'b00} +: 4];
  assign BUSY    = (state != S_IDLE);
  assign GNT     = gnt;

  always_comb begin
    res_next          = acc;
    res_next[W-1 -: 4] = Q;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    winner     = 1'b0;
    A          = 4'd0;
    B          = 4'd0;
    Cin        = 1'b0;
    ENB        = 1'b0;
    MODO       = 2'b00;
    ACK0       = 1'b0;
    ACK1       = 1'b0;
    case (state)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          grant      = 1'b1;
          // On contention the requester the pointer does not name wins.
          winner     = (REQ0 && REQ1) ? ~rr_ptr : REQ1;
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        A    = opa_nib;
        B    = sub_q ? ~opb_nib : opb_nib;
        Cin  = (idx == '0) ? sub_q : RCO;
        ENB  = 1'b1;
        MODO = 2'b01;
        if (idx == IW'(NNIB - 1)) next_state = S_LAST;
      end
      S_LAST: begin
        ENB        = 1'b1;
        next_state = S_CLR;
      end
      S_CLR: begin
        ENB        = 1'b1;
        MODO       = 2'b11;
        ACK0       = ~gnt;
        ACK1       = gnt;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= S_IDLE;
      idx    <= '0;
      rr_ptr <= 1'b1;
      gnt    <= 1'b0;
      sub_q  <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      acc    <= '0;
      RES    <= '0;
      CO     <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (grant) begin
            rr_ptr <= winner;
            gnt    <= winner;
            opa_q  <= winner ? OPA1 : OPA0;
            opb_q  <= winner ? OPB1 : OPB0;
            sub_q  <= winner ? SUB1 : SUB0;
            idx    <= '0;
          end
        end
        S_RUN: begin
          // Q lags one cycle behind the nibble being presented.
          if (idx != '0) acc[{idx - IW'(1), 2'b00} +: 4] <= Q;
          idx <= idx + IW'(1);
        end
        S_LAST: begin
          RES <= res_next;
          CO  <= RCO;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nibble_alu_sched.sv
// Self-checking bench for nibble_alu_sched with a behavioural registered 4-bit sumador.
`default_nettype none

module tb_nibble_alu_sched;

  localparam int NNIB = 8;
  localparam int W    = 4 * NNIB;

  logic         CLK = 1'b0;
  logic         RESET_L = 1'b1;
  logic         REQ0 = 1'b0, REQ1 = 1'b0, SUB0 = 1'b0, SUB1 = 1'b0;
  logic [W-1:0] OPA0 = '0, OPB0 = '0, OPA1 = '0, OPB1 = '0;
  logic         ACK0, ACK1, CO, GNT, BUSY, Cin, ENB, RCO;
  logic [W-1:0] RES;
  logic [3:0]   A, B, Q;
  logic [1:0]   MODO;

  nibble_alu_sched #(.NNIB(NNIB)) dut (
    .CLK(CLK), .RESET_L(RESET_L),
    .REQ0(REQ0), .REQ1(REQ1), .SUB0(SUB0), .SUB1(SUB1),
    .OPA0(OPA0), .OPB0(OPB0), .OPA1(OPA1), .OPB1(OPB1),
    .ACK0(ACK0), .ACK1(ACK1), .RES(RES), .CO(CO), .GNT(GNT), .BUSY(BUSY),
    .A(A), .B(B), .Cin(Cin), .ENB(ENB), .MODO(MODO), .Q(Q), .RCO(RCO)
  );

  always #5 CLK = ~CLK;

  // Registered 4-bit sumador: 00 hold, 01 add, 11 clear.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) {RCO, Q} <= 5'd0;
    else if (ENB) begin
      case (MODO)
        2'b01:   {RCO, Q} <= 5'(A) + 5'(B) + 5'(Cin);
        2'b11:   {RCO, Q} <= 5'd0;
        default: ;
      endcase
    end
  end

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         co;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    logic [W:0] t;
    if (s) begin
      e.res = a - b;
      e.co  = (a >= b);
    end else begin
      t     = (W+1)'(a) + (W+1)'(b);
      e.res = t[W-1:0];
      e.co  = t[W];
    end
    e.id = id;
    sb.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (ACK0 || ACK1) begin
      check("ack_onehot", {ACK1, ACK0} == 2'b11, 0);
      if (sb.size() == 0) check("ack_unexpected", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("ack_id", ACK1 ? 1 : 0, mon_e.id);
        check("res", RES, mon_e.res);
        check("co", CO, mon_e.co);
      end
    end
  end

  task automatic check_reset_outs();
    check("rst_outs", {BUSY, GNT, ACK0, ACK1, ENB, MODO, Cin, A, B, CO}, 0);
    check("rst_res", RES, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_L = 1'b0;
    #1;
    check_reset_outs();
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0]    a_tr = '0, b_tr = '0, bx, res_prev;
    logic [NNIB-1:0] cin_tr = '0, cin_exp;
    logic [4:0]      t5;
    logic            c, res_moved = 1'b0;
    int              edges = 0, m01 = 0, m00 = 0, m11 = 0, nbusy = 0;
    bx = s ? ~b : b;
    c  = s;
    for (int i = 0; i < NNIB; i++) begin
      cin_exp[i] = c;
      t5 = 5'(a[4*i +: 4]) + 5'(bx[4*i +: 4]) + 5'(c);
      c  = t5[4];
    end
    res_prev = RES;
    if (id == 0) begin OPA0 = a; OPB0 = b; SUB0 = s; REQ0 = 1'b1; end
    else         begin OPA1 = a; OPB1 = b; SUB1 = s; REQ1 = 1'b1; end
    push(id, a, b, s);
    while (edges < 20) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (edges == 1) begin
        if (id == 0) begin OPA0 = ~a; OPB0 = ~b; SUB0 = ~s; end
        else         begin OPA1 = ~a; OPB1 = ~b; SUB1 = ~s; end
      end
      if (BUSY) nbusy++;
      if (ENB && MODO == 2'b01) begin
        if (m01 < NNIB) begin
          a_tr[4*m01 +: 4] = A;
          b_tr[4*m01 +: 4] = B;
          cin_tr[m01]      = Cin;
        end
        m01++;
      end else if (ENB && MODO == 2'b00) m00++;
      else if (ENB && MODO == 2'b11) m11++;
      if (!(ACK0 || ACK1) && RES !== res_prev) res_moved = 1'b1;
      if (ACK0 || ACK1) break;
    end
    check("ack_latency", edges, NNIB + 2);
    check("gnt", GNT, id);
    check("run_cycles", m01, NNIB);
    check("last_cycles", m00, 1);
    check("clr_cycles", m11, 1);
    check("busy_cycles", nbusy, NNIB + 2);
    check("a_trace", a_tr, a);
    check("b_trace", b_tr, bx);
    check("cin_trace", cin_tr, cin_exp);
    check("res_hold", res_moved, 0);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("idle_outs", {BUSY, ENB, MODO, Cin, A, B}, 0);
  endtask

  task automatic do_pair(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1);
    int e = 0;
    OPA0 = a0; OPB0 = b0; SUB0 = s0;
    OPA1 = a1; OPB1 = b1; SUB1 = s1;
    push(0, a0, b0, s0);
    push(1, a1, b1, s1);
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    while (e < 30) begin
      @(posedge CLK); e++; @(negedge CLK);
      if (ACK0 || ACK1) break;
    end
    check("pair_first", {ACK1, ACK0}, 2'b01);
    check("pair_first_lat", e, NNIB + 2);
    REQ0 = 1'b0;
    e = 0;
    while (e < 30) begin
      @(posedge CLK); e++; @(negedge CLK);
      if (ACK0 || ACK1) break;
    end
    check("pair_second", {ACK1, ACK0}, 2'b10);
    check("pair_spacing", e, NNIB + 3);
    REQ1 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int e;
    #2 RESET_L = 1'b0;
    #1;
    check_reset_outs();
    @(negedge CLK);
    @(negedge CLK);
    RESET_L = 1'b1;

    do_op(0, 32'hE0E0E0E0, 32'h90909090, 1'b0);
    do_op(1, 32'hE0E0E0E0, 32'h90909090, 1'b1);
    do_op(1, 32'h00000001, 32'h00000002, 1'b1);
    do_op(0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    for (int k = 0; k < 4; k++)
      do_op(k % 2, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    do_reset();
    do_pair(32'h0000_1111, 32'h0000_2222, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1);
    do_pair(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);

    // Abort mid-operation; REQ0 stays high and must be served from scratch.
    OPA0 = 32'hDEAD_BEEF; OPB0 = 32'h0F0F_0F0F; SUB0 = 1'b0; REQ0 = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    RESET_L = 1'b0;
    #1;
    check_reset_outs();
    @(negedge CLK);
    check_reset_outs();
    push(0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1'b0);
    RESET_L = 1'b1;
    e = 0;
    while (e < 20) begin
      @(posedge CLK); e++; @(negedge CLK);
      if (ACK0 || ACK1) break;
    end
    check("post_rst_lat", e, NNIB + 2);
    REQ0 = 1'b0;
    repeat (3) @(negedge CLK);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
